cnc_axil_step_regs: RTL
=======================

# cnc_axil_step_regs

AXI4-Lite slave (responder) for the CNC control block: four 32-bit registers driven by the PS-side AXI master, feeding a single-axis step/direction pulse generator. It sits behind the S00_AXI port of the CNC control IP. Software loads a period and a step count, sets enable, and reads back the remaining count and absolute position.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 4, byte address width; decode on addr[3:2]
- PULSE_W, 4, step pulse high time in clocks (≥1)

- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  reset, asynchronous, active-low
- s00_axi_awaddr / awprot / awvalid / awready  in/in/in/out  4/3/1/1  write address channel
- s00_axi_wdata / wstrb / wvalid / wready  in/in/in/out  32/4/1/1  write data channel
- s00_axi_bresp / bvalid / bready  out/out/in  2/1/1  write response
- s00_axi_araddr / arprot / arvalid / arready  in/in/in/out  4/3/1/1  read address
- s00_axi_rdata / rresp / rvalid / rready  out/out/out/in  32/2/1/1  read data
- step_out  out  1  step pulse
- dir_out  out  1  direction (1 = negative)
- busy  out  1  high while FSM not IDLE
- done_irq  out  1  one-cycle pulse on move completion

## Operation
- Registers: 0x0 CTRL RW (bit0 EN, bit1 DIR, bit2 ABORT self-clearing, bit3 ZERO self-clearing; bits 2,3 and 31:4 read 0); 0x4 PERIOD RW; 0x8 COUNT RW (write loads remaining steps, read returns remaining); 0xC POSITION RO signed, writes ignored with OKAY.
- WSTRB byte enables apply to all RW registers; awprot/arprot ignored; bresp/rresp always OKAY (2'b00).
- Effective period Peff = max(PERIOD, 2*PULSE_W) clocks between rising edges of step_out.
- FSM IDLE: dir_out tracks CTRL.DIR; if EN and COUNT≠0 → HIGH (step_out=1, dir frozen).
- HIGH: after PULSE_W cycles → LOW, step_out=0, COUNT−1, POSITION ±1 per frozen dir.
- LOW: when Peff total cycles elapsed since rising edge: if EN and COUNT≠0 → HIGH, else → IDLE. done_irq pulses the cycle COUNT reaches 0 by decrement.
- EN cleared mid-step: current step completes (HIGH+LOW), then IDLE; COUNT retained.
- ABORT: COUNT←0, FSM→IDLE next cycle, step_out←0; truncated pulse not counted; no done_irq.
- ZERO: POSITION←0; if coincident with a step decrement, ZERO wins.
- COUNT write coincident with decrement: written value wins. POSITION wraps modulo 2^32.

## Timing
- Reset values: all awready/wready/bvalid/arready/rvalid/rdata/step_out/dir_out/busy/done_irq = 0; all registers 0; FSM IDLE.
- Write: awready and wready pulse high together for one cycle when awvalid && wvalid && !bvalid && !awready; register updates on that edge; bvalid rises next cycle, held until bready. No new write accepted while bvalid=1.
- Read: arready pulses one cycle when arvalid && !rvalid && !arready; rvalid with rdata next cycle, rdata stable until rready.
- Register write to step_out effect: EN written at edge N → step_out high at N+2.
- Reset mid-operation: all outputs drop asynchronously; outstanding AXI transactions discarded.

## Test plan
- Reset, read 0x0/0x4/0x8/0xC → all 0x00000000, rresp OKAY, each rvalid one cycle after arready.
- PERIOD=10, COUNT=3, CTRL=0x1 → three 4-cycle step_out pulses, rising edges 10 cycles apart, one done_irq after third, POSITION=3, COUNT=0, busy low.
- Then ZERO-free CTRL=0x3, COUNT=2 → dir_out=1 before first pulse, POSITION=1.
- PERIOD=3 → rising edges 8 cycles apart (clamp 2*PULSE_W).
- PERIOD=20, COUNT=100, EN; write CTRL=0x4 during LOW of 5th step → step_out low, COUNT=0, POSITION +5, no done_irq.
- PERIOD=0x100, write 0xFFFFFFFF with WSTRB=0001 → reads 0x1FF; bready held low 5 cycles → bvalid held, awready stays low for queued write.

Source files
------------

// File: rtl/cnc_axil_step_regs.sv
// AXI4-Lite register slave driving a single-axis step/direction pulse generator.
// Registers: 0x0 CTRL, 0x4 PERIOD, 0x8 COUNT (remaining steps), 0xC POSITION (RO).
module cnc_axil_step_regs #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned PULSE_W            = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic                              step_out,
    output logic                              dir_out,
    output logic                              busy,
    output logic                              done_irq
);

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [DW-1:0] MIN_PERIOD = DW'(2 * PULSE_W);
    localparam logic [DW-1:0] HIGH_LAST  = DW'(PULSE_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    logic          clk;
    logic          rst_n;
    state_t        state_q, state_d;
    logic          ctrl_en_q, ctrl_dir_q, dir_lat_q;
    logic [DW-1:0] period_q, count_q, position_q, cnt_q;
    logic [DW-1:0] peff_c, rdata_c;
    logic [1:0]    wsel_c, rsel_c;
    logic          wr_fire_c, rd_fire_c, ctrl_wr_c, abort_c, zero_c, count_wr_c, period_wr_c;
    logic          dec_c, cnt_clr_c, step_d, busy_d, dir_d;
    logic          unused_c;

    assign clk      = s00_axi_aclk;
    assign rst_n    = s00_axi_aresetn;
    assign unused_c = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // Byte-lane merge of a write into an existing register value
    function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                                 input logic [DW-1:0] data_v,
                                                 input logic [SW-1:0] strb_v);
        logic [DW-1:0] res;
        res = old_v;
        for (int i = 0; i < int'(SW); i++) begin
            if (strb_v[i]) res[i*8 +: 8] = data_v[i*8 +: 8];
        end
        return res;
    endfunction

    // Write/read decode strobes
    always_comb begin
        wr_fire_c   = s00_axi_awready && s00_axi_awvalid && s00_axi_wready && s00_axi_wvalid;
        rd_fire_c   = s00_axi_arready && s00_axi_arvalid;
        wsel_c      = s00_axi_awaddr[3:2];
        rsel_c      = s00_axi_araddr[3:2];
        ctrl_wr_c   = wr_fire_c && (wsel_c == 2'd0) && s00_axi_wstrb[0];
        abort_c     = ctrl_wr_c && s00_axi_wdata[2];
        zero_c      = ctrl_wr_c && s00_axi_wdata[3];
        period_wr_c = wr_fire_c && (wsel_c == 2'd1);
        count_wr_c  = wr_fire_c && (wsel_c == 2'd2) && (|s00_axi_wstrb);
        peff_c      = (period_q > MIN_PERIOD) ? period_q : MIN_PERIOD;
    end

    // Step FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Step FSM next-state logic; abort overrides everything
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (ctrl_en_q && (count_q != '0)) state_d = S_HIGH;
            S_HIGH: if (cnt_q == HIGH_LAST) state_d = S_LOW;
            S_LOW: begin
                if (cnt_q == peff_c - DW'(1)) begin
                    state_d = (ctrl_en_q && (count_q != '0)) ? S_HIGH : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_c) state_d = S_IDLE;
    end

    // Step FSM outputs and datapath strobes
    always_comb begin
        dec_c     = 1'b0;
        cnt_clr_c = 1'b0;
        step_d    = 1'b0;
        busy_d    = 1'b0;
        dir_d     = dir_lat_q;
        dec_c     = (state_q == S_HIGH) && (state_d == S_LOW);
        cnt_clr_c = (state_d == S_HIGH) && (state_q != S_HIGH);
        step_d    = (state_q == S_HIGH);
        busy_d    = (state_q != S_IDLE);
        if (state_q == S_IDLE) dir_d = ctrl_dir_q;
    end

    // Pin outputs registered from the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_out <= 1'b0;
            busy     <= 1'b0;
            dir_out  <= 1'b0;
        end else begin
            step_out <= step_d;
            busy     <= busy_d;
            dir_out  <= dir_d;
        end
    end

    // Cycle counter since the last rising step edge; direction frozen while moving
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            dir_lat_q <= 1'b0;
        end else begin
            if (cnt_clr_c)              cnt_q <= '0;
            else if (state_q != S_IDLE) cnt_q <= cnt_q + DW'(1);
            if (state_q == S_IDLE)      dir_lat_q <= ctrl_dir_q;
        end
    end

    // Control registers, remaining count, position and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en_q  <= 1'b0;
            ctrl_dir_q <= 1'b0;
            period_q   <= '0;
            count_q    <= '0;
            position_q <= '0;
            done_irq   <= 1'b0;
        end else begin
            if (ctrl_wr_c) begin
                ctrl_en_q  <= s00_axi_wdata[0];
                ctrl_dir_q <= s00_axi_wdata[1];
            end
            if (period_wr_c) period_q <= apply_strb(period_q, s00_axi_wdata, s00_axi_wstrb);
            if (abort_c)         count_q <= '0;
            else if (count_wr_c) count_q <= apply_strb(count_q, s00_axi_wdata, s00_axi_wstrb);
            else if (dec_c)      count_q <= count_q - DW'(1);
            if (zero_c)     position_q <= '0;
            else if (dec_c) position_q <= dir_lat_q ? position_q - DW'(1) : position_q + DW'(1);
            done_irq <= dec_c && (count_q == DW'(1)) && !count_wr_c;
        end
    end

    // Write channel handshake and response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
        end else begin
            if (!s00_axi_awready && s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid) begin
                s00_axi_awready <= 1'b1;
                s00_axi_wready  <= 1'b1;
            end else begin
                s00_axi_awready <= 1'b0;
                s00_axi_wready  <= 1'b0;
            end
            if (wr_fire_c)                           s00_axi_bvalid <= 1'b1;
            else if (s00_axi_bvalid && s00_axi_bready) s00_axi_bvalid <= 1'b0;
        end
    end

    // Read data mux
    always_comb begin
        rdata_c = '0;
        case (rsel_c)
            2'd0:    rdata_c = {{(DW-2){1'b0}}, ctrl_dir_q, ctrl_en_q};
            2'd1:    rdata_c = period_q;
            2'd2:    rdata_c = count_q;
            default: rdata_c = position_q;
        endcase
    end

    // Read channel handshake; rdata held until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
        end else begin
            s00_axi_arready <= !s00_axi_arready && s00_axi_arvalid && !s00_axi_rvalid;
            if (rd_fire_c) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= rdata_c;
            end else if (s00_axi_rvalid && s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

    assign s00_axi_bresp = 2'b00;
    assign s00_axi_rresp = 2'b00;

endmodule
